// File: rtl/ofdm_rx_pkg.sv
// Shared definitions for the OFDM receive sample pacer: pacing FSM states
// and the default I/Q sample width.
package ofdm_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFILL = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam int SAMPLE_BIT_WIDTH_C = 12;

endpackage

// File: rtl/ofdm_rx_sample_pacer_if.sv
// Sample streams of the pacer: source side (valid/ready handshake) and
// paced output side (one-cycle valid pulse per sample).
interface ofdm_rx_sample_pacer_if
   import ofdm_rx_pkg::*;
#(
   parameter int sample_bit_width_g = SAMPLE_BIT_WIDTH_C
);

   logic signed [sample_bit_width_g-1:0] in_data_i;
   logic signed [sample_bit_width_g-1:0] in_data_q;
   logic                                 in_valid;
   logic                                 in_ready;
   logic signed [sample_bit_width_g-1:0] rx_data_i;
   logic signed [sample_bit_width_g-1:0] rx_data_q;
   logic                                 rx_data_valid;

   modport master (
      output in_data_i, in_data_q, in_valid,
      input  in_ready, rx_data_i, rx_data_q, rx_data_valid
   );

   modport slave (
      input  in_data_i, in_data_q, in_valid,
      output in_ready, rx_data_i, rx_data_q, rx_data_valid
   );

endinterface

// File: rtl/ofdm_rx_sample_fifo.sv
// Register-array FIFO with pointers one bit wider than the address, so the
// occupancy is the plain pointer difference. Storage has no reset.
module ofdm_rx_sample_fifo #(
   parameter int width_g = 24,
   parameter int depth_g = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [width_g-1:0]       wr_data,
   input  logic                     rd_en,
   output logic [width_g-1:0]       rd_data,
   output logic [$clog2(depth_g):0] level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(depth_g);
   localparam int LW = AW + 1;

   logic [width_g-1:0] r_mem [depth_g];
   logic [LW-1:0]      r_wptr;
   logic [LW-1:0]      r_rptr;
   logic               w_wr;
   logic               w_rd;

   assign w_wr = wr_en & ~full & ~clr;
   assign w_rd = rd_en & ~empty & ~clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + LW'(1);
         if (w_rd) r_rptr <= r_rptr + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= wr_data;
   end

   assign level   = r_wptr - r_rptr;
   assign full    = (level == LW'(depth_g));
   assign empty   = (level == '0);
   assign rd_data = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ofdm_rx_sample_pacer.sv
// Paces buffered I/Q sample pairs out at one pair per strobe_div clocks,
// after the FIFO has been prefilled; flags strobes that find it empty.
module ofdm_rx_sample_pacer
   import ofdm_rx_pkg::*;
#(
   parameter int sample_bit_width_g = SAMPLE_BIT_WIDTH_C,
   parameter int fifo_depth_g       = 16,
   parameter int div_width_g        = 8
)(
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          sys_init,
   input  logic                          enable,
   input  logic [div_width_g-1:0]        strobe_div,
   input  logic [$clog2(fifo_depth_g):0] prefill_level,
   output logic [$clog2(fifo_depth_g):0] fill_level,
   output logic                          underflow,
   ofdm_rx_sample_pacer_if.slave         bus
);

   localparam int SW = sample_bit_width_g;
   localparam int PW = 2 * SW;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [div_width_g-1:0]  r_cnt;
   logic [div_width_g-1:0]  r_div;
   logic [div_width_g-1:0]  r_div_prev;
   logic [div_width_g-1:0]  w_div_eff;
   logic                    w_run;
   logic                    w_div_chg;
   logic                    w_strobe;
   logic                    w_in_ready;
   logic                    w_wr;
   logic                    w_rd;
   logic                    w_full;
   logic                    w_empty;
   logic [PW-1:0]           w_head;
   logic                    r_alive;
   logic                    r_underflow;
   logic                    r_rx_valid;
   logic signed [SW-1:0]    r_rx_i;
   logic signed [SW-1:0]    r_rx_q;

   // r_alive holds in_ready low through reset and releases it on the first clock after.
   assign w_in_ready = r_alive & ~w_full & ~sys_init;
   assign w_wr       = bus.in_valid & w_in_ready;
   assign w_rd       = w_strobe & ~w_empty;

   ofdm_rx_sample_fifo #(
      .width_g (PW),
      .depth_g (fifo_depth_g)
   ) u_fifo (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .clr     (sys_init),
      .wr_en   (w_wr),
      .wr_data ({bus.in_data_i, bus.in_data_q}),
      .rd_en   (w_rd),
      .rd_data (w_head),
      .level   (fill_level),
      .full    (w_full),
      .empty   (w_empty)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)       r_state <= IDLE;
      else if (sys_init) r_state <= IDLE;
      else               r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = PREFILL;
            PREFILL: if (fill_level >= prefill_level) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // The period is latched at each wrap; only a fresh change to a value below
   // the running count cuts the current period short.
   assign w_div_eff = (strobe_div == '0) ? div_width_g'(1) : strobe_div;
   assign w_run     = enable & (r_state == RUN);
   assign w_div_chg = (strobe_div != r_div_prev);
   assign w_strobe  = w_run & ((r_cnt >= r_div - div_width_g'(1)) |
                               (w_div_chg & (w_div_eff < r_cnt)));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_cnt      <= '0;
         r_div      <= div_width_g'(1);
         r_div_prev <= '0;
      end else begin
         r_div_prev <= strobe_div;
         if (sys_init || !w_run || w_strobe) begin
            r_cnt <= '0;
            r_div <= w_div_eff;
         end else begin
            r_cnt <= r_cnt + div_width_g'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_alive     <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_rx_i      <= '0;
         r_rx_q      <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         if (sys_init) begin
            r_rx_valid  <= 1'b0;
            r_rx_i      <= '0;
            r_rx_q      <= '0;
            r_underflow <= 1'b0;
         end else begin
            r_rx_valid <= w_rd;
            if (w_rd) begin
               r_rx_i <= w_head[PW-1:SW];
               r_rx_q <= w_head[SW-1:0];
            end
            if (w_strobe && w_empty) r_underflow <= 1'b1;
         end
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.rx_data_i     = r_rx_i;
   assign bus.rx_data_q     = r_rx_q;
   assign bus.rx_data_valid = r_rx_valid;
   assign underflow         = r_underflow;

endmodule

// File: tb/tb_ofdm_rx_sample_pacer.sv
// Directed bench for ofdm_rx_sample_pacer: prefill, pacing, backpressure,
// underflow, signed pass-through, divider change and mid-run reset.
module tb_ofdm_rx_sample_pacer;

   localparam int SW = 12;
   localparam int DW = 8;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic          init       = 1'b0;
   logic          enable     = 1'b0;
   logic [DW-1:0] strobe_div = 8'd1;
   logic [4:0]    prefill    = 5'd0;
   logic [4:0]    fill;
   logic          underflow;

   ofdm_rx_sample_pacer_if #(.sample_bit_width_g(SW)) bus ();

   ofdm_rx_sample_pacer #(
      .sample_bit_width_g (SW),
      .fifo_depth_g       (16),
      .div_width_g        (DW)
   ) dut (
      .sys_clk       (clk),
      .sys_rst       (rst),
      .sys_init      (init),
      .enable        (enable),
      .strobe_div    (strobe_div),
      .prefill_level (prefill),
      .fill_level    (fill),
      .underflow     (underflow),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Every output pulse is logged with the clock edge that produced it.
   int          q_t[$];
   logic [23:0] q_d[$];
   always @(negedge clk) begin
      if (bus.rx_data_valid === 1'b1) begin
         q_t.push_back(cyc);
         q_d.push_back({bus.rx_data_i, bus.rx_data_q});
      end
   end

   int          n_assert = 0;
   int          n_fail   = 0;
   int          wr_idx;
   int          wr_total;
   logic [11:0] wr_base;
   int          t0;
   int          exp_t5[4] = '{26, 50, 58, 66};
   logic [23:0] d;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic int pair(input logic [11:0] v);
      logic [23:0] p;
      p = {v, ~v};
      return int'(p);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sample(input logic [11:0] v);
      bus.in_data_i = v;
      bus.in_data_q = ~v;
   endtask

   task automatic stream_start(input logic [11:0] base, input int total);
      wr_base      = base;
      wr_total     = total;
      wr_idx       = 0;
      set_sample(base);
      bus.in_valid = (total > 0);
   endtask

   task automatic stream_cycle();
      logic xfer;
      xfer = bus.in_valid && bus.in_ready;
      tick();
      if (xfer) begin
         wr_idx++;
         if (wr_idx >= wr_total) bus.in_valid = 1'b0;
         else                    set_sample(wr_base + 12'(wr_idx));
      end
   endtask

   task automatic soft_init();
      enable = 1'b0;
      init   = 1'b1;
      tick();
      init   = 1'b0;
      tick();
      q_t.delete();
      q_d.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      bus.in_valid = 1'b0;
      set_sample(12'h000);
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rx_i", int'(bus.rx_data_i), 0);
      check_eq("rst_rx_q", int'(bus.rx_data_q), 0);
      check_eq("rst_rx_valid", int'(bus.rx_data_valid), 0);
      check_eq("rst_fill", int'(fill), 0);
      check_eq("rst_underflow", int'(underflow), 0);
      check_eq("rst_in_ready", int'(bus.in_ready), 0);
      rst = 1'b0;
      #1;
      check_eq("rel_in_ready_pre", int'(bus.in_ready), 0);
      tick();
      check_eq("rel_in_ready_post", int'(bus.in_ready), 1);

      // Prefill of 4, 24-clock pacing of samples 1..8.
      prefill    = 5'd4;
      strobe_div = 8'd24;
      stream_start(12'd1, 8);
      enable = 1'b1;
      t0     = cyc;
      for (int k = 0; k < 300 && q_t.size() < 8; k++) stream_cycle();
      check_eq("t1_npulse", q_t.size(), 8);
      for (int j = 0; j < q_t.size(); j++) begin
         check_eq("t1_time", q_t[j] - t0, 29 + 24 * j);
         check_eq("t1_data", int'(q_d[j]), pair(12'(j + 1)));
      end
      check_eq("t1_underflow", int'(underflow), 0);
      check_eq("t1_fill", int'(fill), 0);
      soft_init();

      // Backpressure with pacing halted, then full-rate drain with writes resuming.
      strobe_div = 8'd1;
      prefill    = 5'd0;
      stream_start(12'd101, 52);
      repeat (20) stream_cycle();
      check_eq("t2_accepted", wr_idx, 16);
      check_eq("t2_fill_full", int'(fill), 16);
      check_eq("t2_in_ready_full", int'(bus.in_ready), 0);
      enable = 1'b1;
      t0     = cyc;
      for (int k = 1; k <= 90 && q_t.size() < 52; k++) begin
         stream_cycle();
         if (k >= 4 && k <= 35) check_eq("t2_fill_const", int'(fill), 15);
      end
      check_eq("t2_accepted_all", wr_idx, 52);
      check_eq("t2_npulse", q_t.size(), 52);
      for (int j = 0; j < q_t.size(); j++) begin
         check_eq("t2_time", q_t[j] - t0, 3 + j);
         check_eq("t2_data", int'(q_d[j]), pair(12'(101 + j)));
      end
      soft_init();

      // Single sample, then an empty strobe; sys_init clears the sticky flag.
      strobe_div = 8'd4;
      prefill    = 5'd1;
      stream_start(12'h7FF, 1);
      enable = 1'b1;
      t0     = cyc;
      for (int k = 1; k <= 20; k++) begin
         stream_cycle();
         if (k == 9)  check_eq("t3_uf_before", int'(underflow), 0);
         if (k == 10) check_eq("t3_uf_set", int'(underflow), 1);
      end
      check_eq("t3_uf_sticky", int'(underflow), 1);
      check_eq("t3_npulse", q_t.size(), 1);
      if (q_t.size() > 0) begin
         check_eq("t3_time", q_t[0] - t0, 6);
         check_eq("t3_data", int'(q_d[0]), pair(12'h7FF));
      end
      init = 1'b1;
      tick();
      check_eq("t3_uf_cleared", int'(underflow), 0);
      check_eq("t3_fill_cleared", int'(fill), 0);
      init = 1'b0;
      soft_init();

      // Most negative sample on I, most positive on Q.
      strobe_div = 8'd1;
      prefill    = 5'd1;
      stream_start(12'h800, 1);
      enable = 1'b1;
      for (int k = 0; k < 20 && q_t.size() < 1; k++) stream_cycle();
      check_eq("t4_npulse", q_t.size(), 1);
      d = (q_d.size() > 0) ? q_d[0] : 24'h0;
      check_eq("t4_neg_i", int'($signed(d[23:12])), -2048);
      check_eq("t4_pos_q", int'($signed(d[11:0])), 2047);
      soft_init();

      // Divider change 24 -> 8 mid-period, then reset while a pulse is out.
      strobe_div = 8'd24;
      prefill    = 5'd0;
      stream_start(12'h300, 6);
      repeat (6) stream_cycle();
      enable = 1'b1;
      t0     = cyc;
      for (int k = 1; k <= 74; k++) begin
         stream_cycle();
         if (k == 28) strobe_div = 8'd8;
      end
      check_eq("t5_npulse", q_t.size(), 4);
      for (int j = 0; j < q_t.size() && j < 4; j++) begin
         check_eq("t5_time", q_t[j] - t0, exp_t5[j]);
         check_eq("t5_data", int'(q_d[j]), pair(12'h300 + 12'(j)));
      end
      check_eq("t5_pulse5_valid", int'(bus.rx_data_valid), 1);
      check_eq("t5_pulse5_data", int'({bus.rx_data_i, bus.rx_data_q}), pair(12'h304));
      rst = 1'b1;
      #1;
      check_eq("t5_rst_valid", int'(bus.rx_data_valid), 0);
      check_eq("t5_rst_rx_i", int'(bus.rx_data_i), 0);
      check_eq("t5_rst_rx_q", int'(bus.rx_data_q), 0);
      check_eq("t5_rst_fill", int'(fill), 0);
      check_eq("t5_rst_in_ready", int'(bus.in_ready), 0);
      tick();
      rst    = 1'b0;
      enable = 1'b0;
      check_eq("t5_pulse_suppressed", q_t.size(), 4);
      tick();
      check_eq("t5_in_ready_back", int'(bus.in_ready), 1);
      check_eq("t5_fill_after", int'(fill), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
